// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: fetches one routed channel's word buffer in 1KB-bounded INCR bursts.
// Latency: one CALC cycle per burst, then zero-latency R pass-through; consumer next stalls RREADY directly.
module painterengine_gpu_dma_reader #(
    parameter int PARAM_DATA_ALIGN = 32,
    parameter int PARAM_TIMEOUT    = 256
) (
    input  logic           i_wire_clock,
    input  logic           i_wire_resetn,
    input  logic [3:0]     i_wire_router,
    output logic           o_wire_done,
    input  logic [127:0]   i_wire_address,
    input  logic [127:0]   i_wire_length,
    output logic [127:0]   o_wire_data,
    output logic [3:0]     o_wire_data_valid,
    input  logic [3:0]     i_wire_data_next,
    output logic           o_wire_error,
    output logic [2:0]     o_wire_error_type,
    output logic           o_wire_M_AXI_ARID,
    output logic [31:0]    o_wire_M_AXI_ARADDR,
    output logic [7:0]     o_wire_M_AXI_ARLEN,
    output logic [2:0]     o_wire_M_AXI_ARSIZE,
    output logic [1:0]     o_wire_M_AXI_ARBURST,
    output logic           o_wire_M_AXI_ARLOCK,
    output logic [3:0]     o_wire_M_AXI_ARCACHE,
    output logic [2:0]     o_wire_M_AXI_ARPROT,
    output logic [3:0]     o_wire_M_AXI_ARQOS,
    output logic           o_wire_M_AXI_ARVALID,
    input  logic           i_wire_M_AXI_ARREADY,
    input  logic           i_wire_M_AXI_RID,
    input  logic [31:0]    i_wire_M_AXI_RDATA,
    input  logic [1:0]     i_wire_M_AXI_RRESP,
    input  logic           i_wire_M_AXI_RLAST,
    input  logic           i_wire_M_AXI_RVALID,
    output logic           o_wire_M_AXI_RREADY
);

    localparam int          BYTE_SHIFT = $clog2(PARAM_DATA_ALIGN / 8);
    localparam logic [15:0] TMO_LAST   = 16'(PARAM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_ROUTING,
        S_PARAM_CHECK,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   err_type_d;
    logic [1:0]   idx_q;
    logic [31:0]  addr_q, len_q, offset_q;
    logic [8:0]   blen_q, beat_q;
    logic [15:0]  tmo_q;

    logic         route_ok;
    logic [1:0]   route_idx;
    logic [7:0]   word_pos;
    logic [8:0]   room, blen_calc;
    logic [31:0]  rem, offset_next;
    logic         ar_hs, r_hs, last_beat, tmo_hit;
    logic         unused_rid;

    assign unused_rid = i_wire_M_AXI_RID;

    assign o_wire_M_AXI_ARID    = 1'b0;
    assign o_wire_M_AXI_ARSIZE  = 3'b010;
    assign o_wire_M_AXI_ARBURST = 2'b01;
    assign o_wire_M_AXI_ARLOCK  = 1'b0;
    assign o_wire_M_AXI_ARCACHE = 4'b0010;
    assign o_wire_M_AXI_ARPROT  = 3'b000;
    assign o_wire_M_AXI_ARQOS   = 4'b0000;

    always_comb begin
        route_ok  = 1'b1;
        route_idx = 2'd0;
        case (i_wire_router)
            4'b0001: route_idx = 2'd0;
            4'b0010: route_idx = 2'd1;
            4'b0100: route_idx = 2'd2;
            4'b1000: route_idx = 2'd3;
            default: route_ok  = 1'b0;
        endcase
    end

    // Word position inside the current 1KB window wraps at 256, so room is always 1..256.
    assign word_pos    = addr_q[9:2] + offset_q[7:0];
    assign room        = 9'd256 - {1'b0, word_pos};
    assign rem         = len_q - offset_q;
    assign blen_calc   = (rem < {23'd0, room}) ? rem[8:0] : room;
    assign offset_next = offset_q + {23'd0, blen_q};

    assign ar_hs     = o_wire_M_AXI_ARVALID && i_wire_M_AXI_ARREADY;
    assign r_hs      = i_wire_M_AXI_RVALID && o_wire_M_AXI_RREADY;
    assign last_beat = (beat_q == blen_q - 9'd1);
    assign tmo_hit   = (tmo_q == TMO_LAST);

    always_comb begin
        o_wire_M_AXI_RREADY = 1'b0;
        o_wire_data_valid   = 4'b0000;
        o_wire_data         = '0;
        if (state_q == S_DATA) begin
            o_wire_M_AXI_RREADY                 = i_wire_data_next[idx_q];
            o_wire_data_valid[idx_q]            = i_wire_M_AXI_RVALID;
            o_wire_data[{idx_q, 5'b0} +: 32]    = i_wire_M_AXI_RDATA;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_type_d = 3'd0;
        case (state_q)
            S_ROUTING: begin
                if (i_wire_router != 4'b0000) begin
                    if (route_ok) begin
                        state_d = S_PARAM_CHECK;
                    end else begin
                        state_d    = S_ERROR;
                        err_type_d = 3'd1;
                    end
                end
            end
            S_PARAM_CHECK: begin
                if (addr_q[1:0] != 2'b00) begin
                    state_d    = S_ERROR;
                    err_type_d = 3'd2;
                end else if (len_q == 32'd0) begin
                    state_d    = S_ERROR;
                    err_type_d = 3'd3;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: state_d = S_ADDR;
            S_ADDR: begin
                if (ar_hs) begin
                    state_d = S_DATA;
                end else if (tmo_hit) begin
                    state_d    = S_ERROR;
                    err_type_d = 3'd4;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    if (i_wire_M_AXI_RRESP >= 2'd2) begin
                        state_d    = S_ERROR;
                        err_type_d = 3'd5;
                    end else if (i_wire_M_AXI_RLAST != last_beat) begin
                        state_d    = S_ERROR;
                        err_type_d = 3'd7;
                    end else if (last_beat) begin
                        state_d = (offset_next >= len_q) ? S_DONE : S_CALC;
                    end
                end else if (!i_wire_M_AXI_RVALID && tmo_hit) begin
                    state_d    = S_ERROR;
                    err_type_d = 3'd6;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q              <= S_ROUTING;
            idx_q                <= 2'd0;
            addr_q               <= 32'd0;
            len_q                <= 32'd0;
            offset_q             <= 32'd0;
            blen_q               <= 9'd0;
            beat_q               <= 9'd0;
            tmo_q                <= 16'd0;
            o_wire_M_AXI_ARVALID <= 1'b0;
            o_wire_M_AXI_ARADDR  <= 32'd0;
            o_wire_M_AXI_ARLEN   <= 8'd0;
            o_wire_done          <= 1'b0;
            o_wire_error         <= 1'b0;
            o_wire_error_type    <= 3'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_ROUTING: begin
                    if (state_d == S_PARAM_CHECK) begin
                        idx_q    <= route_idx;
                        addr_q   <= i_wire_address[{route_idx, 5'b0} +: 32];
                        len_q    <= i_wire_length[{route_idx, 5'b0} +: 32];
                        offset_q <= 32'd0;
                    end
                end
                S_CALC: begin
                    o_wire_M_AXI_ARVALID <= 1'b1;
                    o_wire_M_AXI_ARADDR  <= addr_q + (offset_q << BYTE_SHIFT);
                    o_wire_M_AXI_ARLEN   <= 8'(blen_calc - 9'd1);
                    blen_q               <= blen_calc;
                end
                S_ADDR: begin
                    if (state_d != S_ADDR) begin
                        o_wire_M_AXI_ARVALID <= 1'b0;
                        beat_q               <= 9'd0;
                    end
                end
                S_DATA: begin
                    if (r_hs && state_d != S_ERROR) begin
                        beat_q <= beat_q + 9'd1;
                        if (last_beat) begin
                            offset_q <= offset_next;
                        end
                    end
                end
                default: ;
            endcase

            if (state_d == S_DONE) begin
                o_wire_done <= 1'b1;
            end
            if (state_d == S_ERROR && state_q != S_ERROR) begin
                o_wire_error      <= 1'b1;
                o_wire_error_type <= err_type_d;
            end

            // Consumer back-pressure never counts: only a missing RVALID is a stalled slave.
            if (state_d != state_q || ar_hs || r_hs) begin
                tmo_q <= 16'd0;
            end else if (state_q == S_ADDR || (state_q == S_DATA && !i_wire_M_AXI_RVALID)) begin
                tmo_q <= tmo_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for the GPU DMA reader: table of routed transfers against a burst/beat scoreboard,
// plus hand sequences for timeouts, bad responses and reset abort.
module tb_painterengine_gpu_dma_reader;

    logic           clk;
    logic           resetn;
    logic [3:0]     router;
    logic           done;
    logic [127:0]   address;
    logic [127:0]   length;
    logic [127:0]   data;
    logic [3:0]     data_valid;
    logic [3:0]     data_next;
    logic           error;
    logic [2:0]     error_type;
    logic           arid;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arlock;
    logic [3:0]     arcache;
    logic [2:0]     arprot;
    logic [3:0]     arqos;
    logic           arvalid;
    logic           arready;
    logic           rid;
    logic [31:0]    rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    painterengine_gpu_dma_reader dut (
        .i_wire_clock         (clk),
        .i_wire_resetn        (resetn),
        .i_wire_router        (router),
        .o_wire_done          (done),
        .i_wire_address       (address),
        .i_wire_length        (length),
        .o_wire_data          (data),
        .o_wire_data_valid    (data_valid),
        .i_wire_data_next     (data_next),
        .o_wire_error         (error),
        .o_wire_error_type    (error_type),
        .o_wire_M_AXI_ARID    (arid),
        .o_wire_M_AXI_ARADDR  (araddr),
        .o_wire_M_AXI_ARLEN   (arlen),
        .o_wire_M_AXI_ARSIZE  (arsize),
        .o_wire_M_AXI_ARBURST (arburst),
        .o_wire_M_AXI_ARLOCK  (arlock),
        .o_wire_M_AXI_ARCACHE (arcache),
        .o_wire_M_AXI_ARPROT  (arprot),
        .o_wire_M_AXI_ARQOS   (arqos),
        .o_wire_M_AXI_ARVALID (arvalid),
        .i_wire_M_AXI_ARREADY (arready),
        .i_wire_M_AXI_RID     (rid),
        .i_wire_M_AXI_RDATA   (rdata),
        .i_wire_M_AXI_RRESP   (rresp),
        .i_wire_M_AXI_RLAST   (rlast),
        .i_wire_M_AXI_RVALID  (rvalid),
        .o_wire_M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [3:0]  router;
        logic [31:0] addr;
        logic [31:0] len;
        bit          stall;
        bit          exp_done;
        bit          exp_err;
        logic [2:0]  exp_type;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    ar_t          ar_q[$];
    ar_t          exp_ar_q[$];
    logic [31:0]  exp_q[$];
    int           r_beat, g_beat, lane_beats, arv_cycles, lane;
    int           inj_rresp, inj_rlast;
    bit           ar_seen, sb_on, stall, arready_en, r_en;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: observe handshakes on the negedge, then update the slave/consumer after the posedge.
    task automatic step();
        logic         ar_hs, r_hs, lane_hs;
        logic [127:0] exp_full;
        ar_t          e_ar;
        logic [31:0]  e_dat;
        @(negedge clk);
        ar_hs   = arvalid && arready;
        r_hs    = rvalid && rready;
        lane_hs = data_valid[lane] && data_next[lane];
        if (arvalid) arv_cycles++;
        if (ar_hs) begin
            ar_seen = 1'b1;
            ar_q.push_back('{araddr, arlen});
            if (sb_on) begin
                chk("ar_expected", exp_ar_q.size() != 0, 1);
                if (exp_ar_q.size() != 0) begin
                    e_ar = exp_ar_q.pop_front();
                    chk("araddr", araddr, e_ar.addr);
                    chk("arlen", arlen, e_ar.len);
                    chk("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                        {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
                end
            end
        end
        if (lane_hs) begin
            lane_beats++;
            if (sb_on) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_dat    = exp_q.pop_front();
                    exp_full = '0;
                    exp_full[lane*32 +: 32] = e_dat;
                    chk("lane_data", data, exp_full);
                    chk("lane_valid", data_valid, 4'b0001 << lane);
                end
            end
        end
        @(posedge clk);
        #1;
        if (r_hs && ar_q.size() != 0) begin
            g_beat++;
            if (r_beat == int'(ar_q[0].len)) begin
                void'(ar_q.pop_front());
                r_beat = 0;
            end else begin
                r_beat++;
            end
        end
        arready = arready_en && (!stall || $urandom_range(0, 1) == 1);
        if (!(rvalid && !r_hs)) begin
            if (r_en && ar_q.size() != 0 && (!stall || $urandom_range(0, 3) != 0)) begin
                rvalid = 1'b1;
                rdata  = mem(ar_q[0].addr + 32'(4 * r_beat));
                rlast  = (r_beat == int'(ar_q[0].len)) || (g_beat == inj_rlast);
                rresp  = (g_beat == inj_rresp) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
        data_next = stall ? 4'($urandom) : 4'hF;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        router = 4'b0000;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0; rid = 1'b0;
        data_next = 4'b0000;
        ar_q.delete(); exp_ar_q.delete(); exp_q.delete();
        r_beat = 0; g_beat = 0; lane_beats = 0; arv_cycles = 0; ar_seen = 1'b0;
        inj_rresp = -1; inj_rlast = -1; stall = 1'b0; arready_en = 1'b1; r_en = 1'b1; sb_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arlen"}, arlen, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_error_type"}, error_type, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_data"}, data, 0);
    endtask

    task automatic run_until_end(input int budget, input string name);
        int n = 0;
        while (!(done || error) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_finished"}, done || error, 1);
    endtask

    // Start one transfer on a lane, with other lanes filled with junk so a wrong select shows.
    task automatic start(input logic [3:0] rt, input int ln, input logic [31:0] a, input logic [31:0] l);
        lane    = ln;
        address = {$urandom, $urandom, $urandom, $urandom};
        length  = {$urandom, $urandom, $urandom, $urandom};
        address[ln*32 +: 32] = a;
        length[ln*32 +: 32]  = l;
        router = rt;
        step();
        router = 4'b0000;
    endtask

    task automatic build_model(input logic [31:0] a_in, input logic [31:0] len);
        logic [31:0] a;
        int rem, room, b;
        a   = a_in;
        rem = int'(len);
        while (rem > 0) begin
            room = (1024 - int'(a % 1024)) / 4;
            b    = (rem < room) ? rem : room;
            exp_ar_q.push_back('{a, 8'(b - 1)});
            for (int i = 0; i < b; i++) exp_q.push_back(mem(a + 32'(4 * i)));
            a   = a + 32'(4 * b);
            rem = rem - b;
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b0010, 32'h0000_1000, 32'd4,   1'b0, 1'b1, 1'b0, 3'd0};
        vecs[1] = '{4'b0001, 32'h0000_13F8, 32'd5,   1'b0, 1'b1, 1'b0, 3'd0};
        vecs[2] = '{4'b0001, 32'h0000_0000, 32'd600, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[3] = '{4'b1000, 32'h0000_0FFC, 32'd3,   1'b1, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{4'b0100, 32'h0000_2000, 32'd256, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[5] = '{4'b0011, 32'h0000_1000, 32'd4,   1'b0, 1'b0, 1'b1, 3'd1};
        vecs[6] = '{4'b0001, 32'h0000_1002, 32'd4,   1'b0, 1'b0, 1'b1, 3'd2};
        vecs[7] = '{4'b0001, 32'h0000_1000, 32'd0,   1'b0, 1'b0, 1'b1, 3'd3};

        address = '0;
        length  = '0;
        lane    = 0;
        do_reset();
        check_reset_vals("reset");

        for (int v = 0; v < 8; v++) begin
            int ln = 0;
            do_reset();
            for (int i = 3; i >= 0; i--) if (vecs[v].router[i]) ln = i;
            if (!vecs[v].exp_err) build_model(vecs[v].addr, vecs[v].len);
            start(vecs[v].router, ln, vecs[v].addr, vecs[v].len);
            stall = vecs[v].stall;
            run_until_end(6000, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            chk($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
            chk($sformatf("vec%0d_error_type", v), error_type, vecs[v].exp_type);
            chk($sformatf("vec%0d_beats_left", v), exp_q.size(), 0);
            chk($sformatf("vec%0d_bursts_left", v), exp_ar_q.size(), 0);
            if (vecs[v].exp_err) chk($sformatf("vec%0d_no_arvalid", v), ar_seen, 0);
            repeat (3) step();
            chk($sformatf("vec%0d_idle_arvalid", v), arvalid, 0);
            chk($sformatf("vec%0d_idle_rready", v), rready, 0);
            chk($sformatf("vec%0d_sticky", v), {done, error}, {vecs[v].exp_done, vecs[v].exp_err});
        end

        // Address channel never accepted.
        do_reset();
        sb_on = 1'b0;
        arready_en = 1'b0;
        start(4'b0001, 0, 32'h0000_0100, 32'd4);
        repeat (200) step();
        chk("ar_tmo_not_early", error, 0);
        run_until_end(200, "ar_tmo");
        chk("ar_tmo_type", error_type, 3'd4);
        chk("ar_tmo_arvalid_cycles", arv_cycles, 256);
        step();
        chk("ar_tmo_arvalid_drop", arvalid, 0);

        // Address accepted, data never arrives.
        do_reset();
        sb_on = 1'b0;
        r_en  = 1'b0;
        start(4'b0100, 2, 32'h0000_0200, 32'd4);
        run_until_end(400, "r_tmo");
        chk("r_tmo_type", error_type, 3'd6);

        // Slave error response on the third beat.
        do_reset();
        sb_on = 1'b0;
        inj_rresp = 2;
        start(4'b0001, 0, 32'h0000_0000, 32'd4);
        run_until_end(100, "rresp");
        chk("rresp_type", error_type, 3'd5);
        chk("rresp_beats", lane_beats, 3);
        step();
        chk("rresp_rready_low", rready, 0);
        chk("rresp_valid_low", data_valid, 0);

        // RLAST arrives early, on the second of four beats.
        do_reset();
        sb_on = 1'b0;
        inj_rlast = 1;
        start(4'b0010, 1, 32'h0000_0400, 32'd4);
        run_until_end(100, "rlast");
        chk("rlast_type", error_type, 3'd7);
        chk("rlast_beats", lane_beats, 2);

        // Reset in the middle of a data burst.
        do_reset();
        sb_on = 1'b0;
        start(4'b0100, 2, 32'h0000_0000, 32'd600);
        for (int n = 0; n < 100 && lane_beats < 10; n++) step();
        chk("midreset_in_data", lane_beats >= 10, 1);
        resetn = 1'b0;
        #1;
        check_reset_vals("midreset");
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
